aes256_key_expand: RTL and testbench

Iterative AES-256 key schedule generator that sits directly upstream of the round pipeline and supplies the round_key input of every AES round stage. It accepts a 256-bit cipher key with a single-cycle valid strobe. It computes the 15 128-bit round keys, one round key per cycle, and holds them in a register bank presented as one flat bus. A ready flag tells the pipeline that the bank is complete and stable.

---
 rtl/aes256_key_expand_pkg.sv | 47 ++++
 rtl/aes256_key_expand_if.sv | 29 ++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes256_key_expand.sv | 162 ++++++++++++++++
 tb/tb_aes256_key_expand.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/aes256_key_expand_pkg.sv
// Shared AES definitions: round/key-size constants, word and state types,
// key-schedule FSM states, the forward S-box and GF(2^8) xtime.
package aes256_key_expand_pkg;

  localparam int         AES_NR    = 14;
  localparam int         AES_NK    = 8;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } ks_state_e;

  // Forward S-box, byte 0 at the left (most significant) end.
  localparam logic [0:2047] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[{b, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes256_key_expand_if.sv
// Key-in / round-keys-out bundle of the AES-256 key schedule.
// With KEY_STREAM_EN defined the bundle also carries the per-key stream port.
interface aes256_key_expand_if;
  import aes256_key_expand_pkg::*;

  logic [0:32*AES_NK-1]         key;
  logic                         key_ready;
  logic [0:128*(AES_NR+1)-1]    round_keys;
  logic                         keys_ready;
  logic                         busy;
`ifdef KEY_STREAM_EN
  logic [0:127]                 rk_stream;
  logic                         rk_stream_valid;
  logic [3:0]                   rk_stream_idx;

  modport master (output key, key_ready,
                  input  round_keys, keys_ready, busy,
                         rk_stream, rk_stream_valid, rk_stream_idx);
  modport slave  (input  key, key_ready,
                  output round_keys, keys_ready, busy,
                         rk_stream, rk_stream_valid, rk_stream_idx);
`else
  modport master (output key, key_ready,
                  input  round_keys, keys_ready, busy);
  modport slave  (input  key, key_ready,
                  output round_keys, keys_ready, busy);
`endif

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
  import aes256_key_expand_pkg::*;
(
  input  word_t w_i,
  output word_t w_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign w_o[8*gi +: 8] = sbox(w_i[8*gi +: 8]);
  end

endmodule

// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: loads rk0/rk1 from the key, then derives
// one 128-bit round key per cycle into a 15-entry bank exposed as a flat bus.
// Optional KEY_STREAM_EN adds a registered one-key-per-cycle stream port.
module aes256_key_expand
  import aes256_key_expand_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  aes256_key_expand_if.slave  bus
);

  ks_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rcon_q, rcon_d;
  logic       keys_ready_q, keys_ready_d;
  logic       busy_q, busy_d;
  logic       load_en, step_en;

  state_t     rk_q [0:AES_NR];
  state_t     prev2, prev1, rk_new;
  word_t      t_word, sub_in, sub_out, t_mix;
  word_t      q0, q1, q2, q3;
  logic [0:128*(AES_NR+1)-1] bank_flat;

  // Select rk[cnt-2] and rk[cnt-1] as the operands of the current step
  always_comb begin
    prev2 = '0;
    prev1 = '0;
    for (int i = 0; i <= AES_NR; i++) begin
      if (4'(i) == cnt_q - 4'd2) prev2 = rk_q[i];
      if (4'(i) == cnt_q - 4'd1) prev1 = rk_q[i];
    end
  end

  // Even steps rotate and add Rcon; odd steps only substitute (AES-256 Nk=8 rule)
  assign t_word = prev1[31:0];
  assign sub_in = cnt_q[0] ? t_word : {t_word[23:0], t_word[31:24]};

  aes_sub_word u_sub_word (
    .w_i (sub_in),
    .w_o (sub_out)
  );

  assign t_mix  = cnt_q[0] ? sub_out : (sub_out ^ {rcon_q, 24'h000000});
  assign q0     = prev2[127:96] ^ t_mix;
  assign q1     = prev2[95:64]  ^ q0;
  assign q2     = prev2[63:32]  ^ q1;
  assign q3     = prev2[31:0]   ^ q2;
  assign rk_new = {q0, q1, q2, q3};

  // Next-state logic: a key strobe always (re)starts, otherwise step until rk14
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rcon_d       = rcon_q;
    keys_ready_d = keys_ready_q;
    busy_d       = busy_q;
    load_en      = 1'b0;
    step_en      = 1'b0;
    if (bus.key_ready) begin
      load_en      = 1'b1;
      cnt_d        = 4'd2;
      rcon_d       = RCON_INIT;
      keys_ready_d = 1'b0;
      busy_d       = 1'b1;
      state_d      = ST_EXPAND;
    end else begin
      case (state_q)
        ST_EXPAND: begin
          step_en = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          if (!cnt_q[0]) rcon_d = xtime(rcon_q);
          if (cnt_q == 4'(AES_NR)) begin
            keys_ready_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      rcon_q       <= RCON_INIT;
      keys_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcon_q       <= rcon_d;
      keys_ready_q <= keys_ready_d;
      busy_q       <= busy_d;
    end
  end

  // Round-key bank: entries 0/1 come straight from the key, the rest from the step
  for (genvar gi = 0; gi <= AES_NR; gi++) begin : g_bank
    if (gi < 2) begin : g_key
      // Load half of the cipher key
      always_ff @(posedge clk) begin
        if (reset)        rk_q[gi] <= '0;
        else if (load_en) rk_q[gi] <= bus.key[128*gi +: 128];
      end
    end else begin : g_exp
      // Capture the derived key when the counter points here
      always_ff @(posedge clk) begin
        if (reset)                                rk_q[gi] <= '0;
        else if (step_en && cnt_q == 4'(gi))      rk_q[gi] <= rk_new;
      end
    end
    assign bank_flat[128*gi +: 128] = rk_q[gi];
  end

  assign bus.round_keys = bank_flat;
  assign bus.keys_ready = keys_ready_q;
  assign bus.busy       = busy_q;

`ifdef KEY_STREAM_EN
  state_t     stream_q;
  logic       stream_valid_q;
  logic       stream_pend_q;
  logic [3:0] stream_idx_q;

  // Stream each key one cycle after it lands in the bank (rk0 on the load edge);
  // rk14 is written on the final step so it goes out on the following cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      stream_q       <= '0;
      stream_valid_q <= 1'b0;
      stream_idx_q   <= 4'd0;
      stream_pend_q  <= 1'b0;
    end else if (load_en) begin
      stream_q       <= bus.key[0:127];
      stream_valid_q <= 1'b1;
      stream_idx_q   <= 4'd0;
      stream_pend_q  <= 1'b0;
    end else if (step_en) begin
      stream_q       <= prev1;
      stream_valid_q <= 1'b1;
      stream_idx_q   <= cnt_q - 4'd1;
      stream_pend_q  <= (cnt_q == 4'(AES_NR));
    end else if (stream_pend_q) begin
      stream_q       <= rk_q[AES_NR];
      stream_valid_q <= 1'b1;
      stream_idx_q   <= 4'(AES_NR);
      stream_pend_q  <= 1'b0;
    end else begin
      stream_valid_q <= 1'b0;
    end
  end

  assign bus.rk_stream       = stream_q;
  assign bus.rk_stream_valid = stream_valid_q;
  assign bus.rk_stream_idx   = stream_idx_q;
`endif

endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed bench for aes256_key_expand using FIPS-197 C.3 and A.3 keys.
// Define KEY_STREAM_EN to also exercise the stream port.
module tb_aes256_key_expand;
  import aes256_key_expand_pkg::*;

  localparam logic [0:255] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:255] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] C3_RK [0:14] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'h101112131415161718191a1b1c1d1e1f,
    128'ha573c29fa176c498a97fce93a572c09c,
    128'h1651a8cd0244beda1a5da4c10640bade,
    128'hae87dff00ff11b68a68ed5fb03fc1567,
    128'h6de1f1486fa54f9275f8eb5373b8518d,
    128'hc656827fc9a799176f294cec6cd5598b,
    128'h3de23a75524775e727bf9eb45407cf39,
    128'h0bdc905fc27b0948ad5245a4c1871c2f,
    128'h45f5a66017b2d387300d4d33640a820a,
    128'h7ccff71cbeb4fe5413e6bbf0d261a7df,
    128'hf01afafee7a82979d7a5644ab3afe640,
    128'h2541fe719bf500258813bbd55a721c0a,
    128'h4e5a6699a9f24fe07e572baacdf8cdea,
    128'h24fc79ccbf0979e9371ac23c6d68de36
  };

  logic clk = 1'b0;
  logic reset;

  aes256_key_expand_if kif ();

  aes256_key_expand dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int bcnt;
  logic [127:0] r;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rk_at(input logic [0:1919] bank, input int n);
    return bank[128*n +: 128];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [0:255] k);
    kif.key       = k;
    kif.key_ready = 1'b1;
    tick();
    kif.key_ready = 1'b0;
  endtask

  // Bounded wait for keys_ready; cycles counted from the edge after the strobe
  task automatic wait_ready(output int c, output int b);
    c = 0;
    b = int'(kif.busy);
    while (kif.keys_ready !== 1'b1 && c < 40) begin
      tick();
      c++;
      if (kif.busy === 1'b1) b++;
    end
  endtask

  task automatic chk_bank_c3(input string pfx);
    for (int i = 0; i < 15; i++)
      chk($sformatf("%s_rk%0d", pfx, i), rk_at(kif.round_keys, i), C3_RK[i]);
  endtask

  initial begin
    reset         = 1'b1;
    kif.key       = '0;
    kif.key_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    $display("reset released");
    chk("rst_bank_nonzero", 128'(|kif.round_keys), 128'd0);
    chk("rst_keys_ready", 128'(kif.keys_ready), 128'd0);
    chk("rst_busy", 128'(kif.busy), 128'd0);

    // C.3 key, full bank against the published schedule
    $display("strobe C.3 key");
    strobe(KEY_C3);
    chk("c3_busy_e0", 128'(kif.busy), 128'd1);
    chk("c3_kr_e0", 128'(kif.keys_ready), 128'd0);
    wait_ready(cyc, bcnt);
    chk("c3_latency", 128'(cyc + 1), 128'd14);
    chk_bank_c3("c3");

    // A.3 key from DONE; keys_ready must drop on the accepting edge
    $display("strobe A.3 key from DONE");
    strobe(KEY_A3);
    chk("a3_kr_drop", 128'(kif.keys_ready), 128'd0);
    wait_ready(cyc, bcnt);
    chk("a3_latency", 128'(cyc + 1), 128'd14);
    chk("a3_busy_cycles", 128'(bcnt), 128'd13);
    r = rk_at(kif.round_keys, 2);
    chk("a3_rk2_w0", 128'(r[127:96]), 128'h9ba35411);
    r = rk_at(kif.round_keys, 14);
    chk("a3_rk14_w3", 128'(r[31:0]), 128'h706c631e);

    // Restart mid-expansion with the C.3 key
    $display("strobe A.3 then restart with C.3 at cycle 6");
    strobe(KEY_A3);
    repeat (5) tick();
    chk("rs_kr_mid", 128'(kif.keys_ready), 128'd0);
    strobe(KEY_C3);
    chk("rs_kr_restart", 128'(kif.keys_ready), 128'd0);
    chk("rs_rk0_loaded", rk_at(kif.round_keys, 0), C3_RK[0]);
    wait_ready(cyc, bcnt);
    chk("rs_latency", 128'(cyc + 1), 128'd14);
    chk_bank_c3("rs");

    // Reset in the middle of an expansion
    $display("strobe A.3 then reset at cycle 5");
    strobe(KEY_A3);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("mr_bank_nonzero", 128'(|kif.round_keys), 128'd0);
    chk("mr_keys_ready", 128'(kif.keys_ready), 128'd0);
    chk("mr_busy", 128'(kif.busy), 128'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("mr_idle_busy", 128'(kif.busy), 128'd0);
    chk("mr_idle_bank", 128'(|kif.round_keys), 128'd0);
    $display("strobe C.3 after reset");
    strobe(KEY_C3);
    wait_ready(cyc, bcnt);
    chk("mr_latency", 128'(cyc + 1), 128'd14);
    chk("mr_rk14", rk_at(kif.round_keys, 14), C3_RK[14]);

    // Strobe coincident with reset is discarded
    $display("strobe A.3 together with reset");
    kif.key       = KEY_A3;
    kif.key_ready = 1'b1;
    reset         = 1'b1;
    tick();
    kif.key_ready = 1'b0;
    reset         = 1'b0;
    chk("rk_bank_nonzero", 128'(|kif.round_keys), 128'd0);
    chk("rk_busy", 128'(kif.busy), 128'd0);
    chk("rk_keys_ready", 128'(kif.keys_ready), 128'd0);
    repeat (3) tick();
    chk("rk_no_start", 128'(kif.busy), 128'd0);

    // Two-cycle strobe in DONE: restart counted from the second edge
    $display("strobe C.3 then A.3 held two cycles");
    strobe(KEY_C3);
    wait_ready(cyc, bcnt);
    chk("h2_c3_latency", 128'(cyc + 1), 128'd14);
    kif.key       = KEY_A3;
    kif.key_ready = 1'b1;
    tick();
    chk("h2_kr_first", 128'(kif.keys_ready), 128'd0);
    tick();
    kif.key_ready = 1'b0;
    wait_ready(cyc, bcnt);
    chk("h2_latency", 128'(cyc + 1), 128'd14);
    r = rk_at(kif.round_keys, 2);
    chk("h2_rk2_w0", 128'(r[127:96]), 128'h9ba35411);
    r = rk_at(kif.round_keys, 14);
    chk("h2_rk14_w3", 128'(r[31:0]), 128'h706c631e);

`ifdef KEY_STREAM_EN
    // Stream port: 15 consecutive keys, indices 0..14
    $display("stream C.3 key");
    strobe(KEY_C3);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) tick();
      chk($sformatf("st_valid%0d", i), 128'(kif.rk_stream_valid), 128'd1);
      chk($sformatf("st_idx%0d", i), 128'(kif.rk_stream_idx), 128'(i));
      chk($sformatf("st_data%0d", i), 128'(kif.rk_stream), C3_RK[i]);
    end
    tick();
    chk("st_valid_end", 128'(kif.rk_stream_valid), 128'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
